branch_sched: RTL and testbench
===============================

Name: branch_sched

Overview:
Shared-resource scheduler for the single branch compare unit in the dual-issue execute stage.
- Arbitrates branch requests from two issue slots (slot 0 older, slot 1 younger) onto one compare unit, driving its a/b/operation inputs and sampling its combinational result.
- Detects mispredictions and issues a one-cycle front-end redirect, then squashes wrong-path branch requests.
- Buffers predictor-update records in a small FIFO with a valid/ready handshake toward the BHT/BTB.

Parameters:
XLEN, 32, data/address width
UPD_DEPTH, 2, update FIFO depth (power of 2, >=2)
SQUASH_CYCLES, 2, cycles wrong-path requests are discarded after a redirect (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  2  per-slot branch request valid
req_ready_o  out  2  per-slot accept; request consumed when valid&ready
req_rs1_i  in  2xXLEN  per-slot operand a
req_rs2_i  in  2xXLEN  per-slot operand b
req_op_i  in  2x3  per-slot branch operation select (funct3 encoding)
req_pc_i  in  2xXLEN  per-slot branch PC
req_target_i  in  2xXLEN  per-slot computed taken target
req_pred_taken_i  in  2  per-slot predicted direction
req_pred_target_i  in  2xXLEN  per-slot predicted target
bu_a_o  out  XLEN  compare unit operand a
bu_b_o  out  XLEN  compare unit operand b
bu_op_o  out  3  compare unit operation select
bu_result_i  in  1  compare unit result (combinational, same cycle)
flush_i  in  1  pipeline flush (exception/trap), synchronous
redirect_valid_o  out  1  registered one-cycle redirect pulse
redirect_pc_o  out  XLEN  redirect PC, valid with redirect_valid_o
upd_valid_o  out  1  update FIFO head valid
upd_ready_i  in  1  predictor accepts head
upd_pc_o  out  XLEN  head branch PC
upd_taken_o  out  1  head actual direction
upd_target_o  out  XLEN  head taken target

Behaviour:
- Reset (rst_i=1, asynchronous): state=IDLE, squash counter=0, FIFO empty. redirect_valid_o=0, redirect_pc_o=0, upd_valid_o=0, req_ready_o=2'b00 while rst_i is asserted.
- States: IDLE (normal resolve), SQUASH (discard wrong path).
- IDLE grant: slot 0 wins if req_valid_i[0]; otherwise slot 1. At most one grant per cycle.
  - req_ready_o[g]=1 only for the granted slot and only when FIFO not full or a pop occurs this cycle (upd_valid_o&upd_ready_i).
  - Non-granted slot: ready=0; it holds its request.
- bu_a_o/bu_b_o/bu_op_o are combinational muxes of the granted slot; slot 0 fields are driven when there is no grant.
- On accept: taken=bu_result_i. Push {pc, taken, target} to the FIFO at the clock edge.
- Mispredict = (taken != pred_taken) | (taken & pred_target != target).
  - On mispredict: next cycle redirect_valid_o=1, redirect_pc_o = taken ? target : pc+4 (mod 2^XLEN). Enter SQUASH with counter=SQUASH_CYCLES.
- SQUASH: req_ready_o = req_valid_i; requests are consumed and dropped (no compare, no push, no redirect). Counter decrements each cycle; return to IDLE when the counter reaches 1 (state is SQUASH for exactly SQUASH_CYCLES cycles).
- redirect_valid_o is a single-cycle pulse; it never asserts on consecutive cycles.
- flush_i=1: next state IDLE, counter cleared. Any redirect that would issue next cycle is suppressed. req_ready_o=0 in the flush cycle. FIFO contents are kept. flush_i and a mispredicting accept in the same cycle: flush wins, no redirect, and the record is not pushed.
- FIFO: head shown on upd_* whenever non-empty; upd_* hold stable while upd_valid_o&!upd_ready_i. Simultaneous push and pop at full is allowed. Pointers wrap modulo UPD_DEPTH.
- Reset mid-SQUASH or with a non-empty FIFO returns everything to reset values immediately.

Test Plan:
- Both slots valid; slot0 BEQ a=b=5 pred_taken=1 target=0x100=pred_target; slot1 BNE 1,2 -> cycle0 ready=01, slot0 accepted, no redirect; cycle1 ready=10; two FIFO entries (pc0 taken=1, pc1 taken=1).
- Slot0 BLT a=0xFFFFFFFF b=1 pred_taken=0 pc=0x200 target=0x180 -> next cycle redirect_valid_o=1 with redirect_pc_o=0x180; slot1 requests in the following 2 cycles are accepted and dropped (no FIFO push).
- BGEU a=1 b=0xFFFFFFFF pred_taken=1 pc=0xFFFFFFFC -> not taken, redirect_pc_o=0x00000000 (wrap).
- upd_ready_i=0, 2 accepts fill FIFO -> req_ready_o=00 with a request pending; raise upd_ready_i -> same-cycle accept with pop, FIFO remains full, head ordering preserved.
- Mispredicting accept with flush_i=1 in the same cycle -> no redirect, no push, state IDLE.
- Assert rst_i asynchronously mid-SQUASH with 1 FIFO entry -> all outputs 0 immediately; after release, normal grant resumes.

Source files
------------

// File: rtl/branch_sched.sv
// Branch compare-unit scheduler for the dual-issue execute stage: arbitrates two
// issue slots onto one compare unit, raises front-end redirects and queues predictor updates.
module branch_sched #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned UPD_DEPTH     = 2,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [1:0][XLEN-1:0] req_rs1_i,
    input  logic [1:0][XLEN-1:0] req_rs2_i,
    input  logic [1:0][2:0]      req_op_i,
    input  logic [1:0][XLEN-1:0] req_pc_i,
    input  logic [1:0][XLEN-1:0] req_target_i,
    input  logic [1:0]           req_pred_taken_i,
    input  logic [1:0][XLEN-1:0] req_pred_target_i,

    output logic [XLEN-1:0]      bu_a_o,
    output logic [XLEN-1:0]      bu_b_o,
    output logic [2:0]           bu_op_o,
    input  logic                 bu_result_i,

    input  logic                 flush_i,

    output logic                 redirect_valid_o,
    output logic [XLEN-1:0]      redirect_pc_o,

    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic [XLEN-1:0]      upd_pc_o,
    output logic                 upd_taken_o,
    output logic [XLEN-1:0]      upd_target_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    localparam int unsigned AW = $clog2(UPD_DEPTH);
    localparam int unsigned CW = $clog2(SQUASH_CYCLES + 1);

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   sq_cnt_q, sq_cnt_d;

    logic [XLEN-1:0] fifo_pc    [UPD_DEPTH];
    logic            fifo_taken [UPD_DEPTH];
    logic [XLEN-1:0] fifo_tgt   [UPD_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;

    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            grant_any;
    logic            gsel;
    logic            sel;
    logic            accept;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc_d;

    assign fifo_full   = (count_q == (AW+1)'(UPD_DEPTH));
    assign upd_valid_o = (count_q != '0);
    assign pop         = upd_valid_o & upd_ready_i;

    assign upd_pc_o     = fifo_pc[rd_ptr_q];
    assign upd_taken_o  = fifo_taken[rd_ptr_q];
    assign upd_target_o = fifo_tgt[rd_ptr_q];

    // Slot 0 is older and always wins; slot 1 only when slot 0 is idle.
    assign grant_any = (state_q == ST_IDLE) && !flush_i && (req_valid_i != 2'b00);
    assign gsel      = !req_valid_i[0];
    assign sel       = grant_any ? gsel : 1'b0;

    always_comb begin
        req_ready_o = '0;
        if (!rst_i && !flush_i) begin
            if (state_q == ST_SQUASH) begin
                req_ready_o = req_valid_i;
            end else if (grant_any && (!fifo_full || pop)) begin
                req_ready_o[gsel] = 1'b1;
            end
        end
    end

    assign bu_a_o  = req_rs1_i[sel];
    assign bu_b_o  = req_rs2_i[sel];
    assign bu_op_o = req_op_i[sel];

    assign accept     = (state_q == ST_IDLE) && req_ready_o[sel];
    assign push       = accept;
    assign taken      = bu_result_i;
    assign mispredict = (taken != req_pred_taken_i[sel]) ||
                        (taken && (req_pred_target_i[sel] != req_target_i[sel]));
    assign redirect_pc_d = taken ? req_target_i[sel] : (req_pc_i[sel] + XLEN'(4));

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        if (flush_i) begin
            state_d  = ST_IDLE;
            sq_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && mispredict) begin
                        state_d  = ST_SQUASH;
                        sq_cnt_d = CW'(SQUASH_CYCLES);
                    end
                end
                ST_SQUASH: begin
                    if (sq_cnt_q == CW'(1)) begin
                        state_d  = ST_IDLE;
                        sq_cnt_d = '0;
                    end else begin
                        sq_cnt_d = sq_cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sq_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            sq_cnt_q         <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            state_q          <= state_d;
            sq_cnt_q         <= sq_cnt_d;
            redirect_valid_o <= accept && mispredict;
            if (accept && mispredict) begin
                redirect_pc_o <= redirect_pc_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= req_pc_i[sel];
            fifo_taken[wr_ptr_q] <= taken;
            fifo_tgt[wr_ptr_q]   <= req_target_i[sel];
        end
    end

endmodule

// File: tb/tb_branch_sched.sv
// Randomised bench for branch_sched, checked every cycle against a queue-based
// reference model that also acts as the combinational compare unit.
module tb_branch_sched;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int SQ    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           valid;
    logic [1:0]           ready;
    logic [1:0][XLEN-1:0] rs1, rs2, pc, tgt, ptgt;
    logic [1:0][2:0]      op;
    logic [1:0]           pt;
    logic [XLEN-1:0]      bu_a, bu_b;
    logic [2:0]           bu_op;
    logic                 bu_result;
    logic                 flush;
    logic                 redir_v;
    logic [XLEN-1:0]      redir_pc;
    logic                 upd_v, upd_rdy, upd_taken;
    logic [XLEN-1:0]      upd_pc, upd_tgt;

    always #5 clk = ~clk;

    branch_sched #(.XLEN(XLEN), .UPD_DEPTH(DEPTH), .SQUASH_CYCLES(SQ)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_ready_o(ready),
        .req_rs1_i(rs1), .req_rs2_i(rs2), .req_op_i(op),
        .req_pc_i(pc), .req_target_i(tgt),
        .req_pred_taken_i(pt), .req_pred_target_i(ptgt),
        .bu_a_o(bu_a), .bu_b_o(bu_b), .bu_op_o(bu_op), .bu_result_i(bu_result),
        .flush_i(flush),
        .redirect_valid_o(redir_v), .redirect_pc_o(redir_pc),
        .upd_valid_o(upd_v), .upd_ready_i(upd_rdy),
        .upd_pc_o(upd_pc), .upd_taken_o(upd_taken), .upd_target_o(upd_tgt)
    );

    // RISC-V branch semantics keyed by funct3.
    function automatic logic br_cmp(logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [2:0] f3);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign bu_result = br_cmp(bu_a, bu_b, bu_op);

    typedef struct {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] tgt;
    } rec_t;

    rec_t            q[$];
    int              sq_left;
    logic            m_rv;
    logic [XLEN-1:0] m_rpc;
    logic [1:0]      last_acc;
    int              n_checks = 0;
    int              n_pass   = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic set_req(int s, logic v, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [2:0] f3,
                           logic [XLEN-1:0] p, logic [XLEN-1:0] t, logic ptk, logic [XLEN-1:0] ptg);
        valid[s] = v; rs1[s] = a; rs2[s] = b; op[s] = f3;
        pc[s] = p; tgt[s] = t; pt[s] = ptk; ptgt[s] = ptg;
    endtask

    task automatic model_reset();
        q.delete();
        sq_left  = 0;
        m_rv     = 1'b0;
        m_rpc    = '0;
        last_acc = '0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic [1:0]      er;
        int              g;
        logic            do_pop, acc, tk, mis, do_push;
        rec_t            r;
        int              nsq;
        logic            nrv;
        logic [XLEN-1:0] nrpc;
        @(negedge clk);
        er     = '0;
        g      = valid[0] ? 0 : 1;
        do_pop = (q.size() > 0) && upd_rdy;
        if (!flush) begin
            if (sq_left > 0) er = valid;
            else if (valid != 2'b00 && (q.size() < DEPTH || do_pop)) er[g] = 1'b1;
        end
        check("req_ready", ready, er);
        check("redirect_valid", redir_v, m_rv);
        if (m_rv) check("redirect_pc", redir_pc, m_rpc);
        check("upd_valid", upd_v, q.size() > 0);
        if (q.size() > 0) begin
            check("upd_pc", upd_pc, q[0].pc);
            check("upd_taken", upd_taken, q[0].taken);
            check("upd_target", upd_tgt, q[0].tgt);
        end
        acc     = (sq_left == 0) && (er != 2'b00);
        do_push = 1'b0;
        nsq     = sq_left;
        nrv     = 1'b0;
        nrpc    = m_rpc;
        r       = '{pc: '0, taken: 1'b0, tgt: '0};
        if (flush) begin
            nsq = 0;
        end else if (sq_left > 0) begin
            nsq = sq_left - 1;
        end else if (acc) begin
            check("bu_a", bu_a, rs1[g]);
            check("bu_b", bu_b, rs2[g]);
            check("bu_op", bu_op, op[g]);
            tk      = br_cmp(rs1[g], rs2[g], op[g]);
            r       = '{pc: pc[g], taken: tk, tgt: tgt[g]};
            do_push = 1'b1;
            mis     = (tk != pt[g]) || (tk && ptgt[g] != tgt[g]);
            if (mis) begin
                nrv  = 1'b1;
                nrpc = tk ? tgt[g] : pc[g] + 32'd4;
                nsq  = SQ;
            end
        end
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(r);
        sq_left  = nsq;
        m_rv     = nrv;
        m_rpc    = nrpc;
        last_acc = er;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_redirect_valid", redir_v, 1'b0);
        check("rst_redirect_pc", redir_pc, '0);
        check("rst_upd_valid", upd_v, 1'b0);
        check("rst_req_ready", ready, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [XLEN-1:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return XLEN'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - XLEN'($urandom_range(0, 2));
            2:       return 32'h8000_0000;
            default: return XLEN'($urandom);
        endcase
    endfunction

    task automatic rand_req(int s);
        logic [2:0]      f3;
        logic [XLEN-1:0] p, t;
        case ($urandom_range(0, 5))
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b100;
            3: f3 = 3'b101; 4: f3 = 3'b110; default: f3 = 3'b111;
        endcase
        p = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : (XLEN'($urandom) & 32'hFFFF_FFFC);
        t = XLEN'($urandom) & 32'hFFFF_FFFC;
        set_req(s, $urandom_range(0, 9) < 7, rand_opnd(), rand_opnd(), f3, p, t,
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? p : t);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; upd_rdy = 1'b0;
        valid = '0; rs1 = '0; rs2 = '0; op = '0; pc = '0; tgt = '0; pt = '0; ptgt = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_redirect_valid", redir_v, 1'b0);
        check("reset_upd_valid", upd_v, 1'b0);
        check("reset_req_ready", ready, 2'b00);
        rst = 1'b0;

        // Both slots valid, correct predictions, FIFO held full.
        set_req(0, 1, 5, 5, 3'b000, 32'h40, 32'h100, 1, 32'h100);
        set_req(1, 1, 1, 2, 3'b001, 32'h44, 32'h200, 1, 32'h200);
        cycle();
        valid[0] = 1'b0;
        cycle();
        valid = '0;
        cycle();
        upd_rdy = 1'b1;
        repeat (2) cycle();

        // Signed BLT taken but predicted not-taken; slot 1 dropped while squashing.
        set_req(0, 1, 32'hFFFF_FFFF, 1, 3'b100, 32'h200, 32'h180, 0, 32'h0);
        set_req(1, 1, 3, 3, 3'b000, 32'h204, 32'h300, 1, 32'h300);
        cycle();
        valid[0] = 1'b0;
        cycle();
        set_req(1, 1, 4, 4, 3'b000, 32'h208, 32'h310, 1, 32'h310);
        repeat (3) cycle();

        // Not-taken BGEU at the top of the address space: pc+4 wraps to zero.
        set_req(0, 1, 1, 32'hFFFF_FFFF, 3'b111, 32'hFFFF_FFFC, 32'h10, 1, 32'h10);
        valid[1] = 1'b0;
        cycle();
        valid = '0;
        repeat (3) cycle();

        // Fill the FIFO with the predictor stalled, then release it.
        upd_rdy = 1'b0;
        set_req(0, 1, 7, 7, 3'b000, 32'h500, 32'h600, 1, 32'h600);
        cycle();
        set_req(0, 1, 7, 8, 3'b000, 32'h504, 32'h700, 0, 32'h0);
        cycle();
        set_req(0, 1, 2, 1, 3'b110, 32'h508, 32'h800, 0, 32'h0);
        cycle();
        upd_rdy = 1'b1;
        cycle();
        valid = '0;
        repeat (4) cycle();

        // Flush coinciding with a mispredicting request.
        set_req(0, 1, 9, 9, 3'b000, 32'h900, 32'hA00, 0, 32'h0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        valid = '0;
        repeat (2) cycle();

        // Async reset while squashing with one queued record.
        upd_rdy = 1'b0;
        set_req(0, 1, 1, 2, 3'b001, 32'hB00, 32'hC00, 0, 32'h0);
        cycle();
        valid = '0;
        async_reset();
        set_req(0, 1, 3, 3, 3'b000, 32'hD00, 32'hE00, 1, 32'hE00);
        cycle();
        valid = '0;
        cycle();

        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (!valid[s] || last_acc[s]) rand_req(s);
            end
            flush   = ($urandom_range(0, 19) == 0);
            upd_rdy = ($urandom_range(0, 9) < 6);
            if (i == 300) async_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
